// File: rtl/lcd_write_sequencer_pkg.sv
// Shared state encoding, default 50 MHz timing and a parameter range check
// for the HD44780 write sequencer.
package lcd_write_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_EXEC  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int DEF_T_SETUP = 3;
    localparam int DEF_T_PW    = 12;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_T_GAP   = 50;
    localparam int DEF_T_EXEC  = 2000;
    localparam int DEF_CNT_W   = 16;

    // A timed state of T cycles loads T-1, which must fit in w bits.
    function automatic bit t_ok(int t, int w);
        return (t >= 1) && (longint'(t) <= (longint'(1) << w));
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_timer.sv
// Loadable down-counter; oExpired is high once the count reaches zero.
// Ports: Clock, iReset_n, iLoad, iCount[CNT_W], oExpired.
module lcd_write_sequencer_timer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             iReset_n,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iCount,
    output logic             oExpired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= iCount;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign oExpired = (cnt == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 write sequencer: one byte per start, 8-bit or 4-bit mode.
// Ports: Clock/iReset_n, iStart/iRS/iData/iNibbleMode in; oBusy/oDone and LCD pins out.
module lcd_write_sequencer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int T_SETUP_CYC = DEF_T_SETUP,
    parameter int T_PW_CYC    = DEF_T_PW,
    parameter int T_HOLD_CYC  = DEF_T_HOLD,
    parameter int T_GAP_CYC   = DEF_T_GAP,
    parameter int T_EXEC_CYC  = DEF_T_EXEC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       Clock,
    input  logic       iReset_n,
    input  logic       iStart,
    input  logic       iRS,
    input  logic [7:0] iData,
    input  logic       iNibbleMode,
    output logic       oBusy,
    output logic       oDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic [7:0] oLCD_Data
);

    if (!t_ok(T_SETUP_CYC, CNT_W) || !t_ok(T_PW_CYC, CNT_W) ||
        !t_ok(T_HOLD_CYC, CNT_W) || !t_ok(T_GAP_CYC, CNT_W) ||
        !t_ok(T_EXEC_CYC, CNT_W)) begin : g_bad_timing
        $error("lcd_write_sequencer: timing parameter out of range");
    end

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);

    state_t           state;
    logic             nib;
    logic             second;
    logic [3:0]       lo_nib;
    logic             expired;
    logic             load;
    logic [CNT_W-1:0] load_val;

    // The timer is reloaded on the same edge as every state change, so
    // each timed state lasts exactly its programmed number of cycles.
    assign load = (state == ST_IDLE) || expired;

    always_comb begin
        load_val = '0;
        unique case (state)
            ST_IDLE:  load_val = LD_SETUP;
            ST_SETUP: load_val = LD_PW;
            ST_PULSE: load_val = LD_HOLD;
            ST_HOLD:  load_val = (nib && !second) ? LD_GAP : LD_EXEC;
            ST_GAP:   load_val = LD_SETUP;
            ST_EXEC:  load_val = '0;
            ST_DONE:  load_val = LD_SETUP;
            default:  load_val = '0;
        endcase
    end

    lcd_write_sequencer_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clock    (Clock),
        .iReset_n (iReset_n),
        .iLoad    (load),
        .iCount   (load_val),
        .oExpired (expired)
    );

    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state               <= ST_IDLE;
            nib                 <= 1'b0;
            second              <= 1'b0;
            lo_nib              <= 4'h0;
            oBusy               <= 1'b0;
            oDone               <= 1'b0;
            oLCD_Enabled        <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oLCD_Data           <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        nib                 <= iNibbleMode;
                        second              <= 1'b0;
                        lo_nib              <= iData[3:0];
                        oLCD_RegisterSelect <= iRS;
                        oLCD_Data           <= iNibbleMode ?
                                               {iData[7:4], 4'h0} : iData;
                        oBusy               <= 1'b1;
                        state               <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (expired) begin
                        oLCD_Enabled <= 1'b1;
                        state        <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (expired) begin
                        oLCD_Enabled <= 1'b0;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (expired) begin
                        state <= (nib && !second) ? ST_GAP : ST_EXEC;
                    end
                end
                ST_GAP: begin
                    // Low nibble goes out on the upper lines for pass two.
                    if (expired) begin
                        oLCD_Data <= {lo_nib, 4'h0};
                        second    <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_EXEC: begin
                    if (expired) begin
                        oDone <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oLCD_ReadWrite = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Randomised directed bench for lcd_write_sequencer with a timeline model
// derived from the per-phase cycle counts.
module tb_lcd_write_sequencer;

    localparam int DS = 3;
    localparam int DP = 12;
    localparam int DH = 2;
    localparam int DG = 50;
    localparam int DE = 2000;

    logic       Clock;
    logic       iReset_n;
    logic       iStart;
    logic       iStart1;
    logic       iRS;
    logic [7:0] iData;
    logic       iNibbleMode;

    logic       busy, done, en, rs, rw;
    logic [7:0] dat;
    logic       busy1, done1, en1, rs1, rw1;
    logic [7:0] dat1;

    int vectors;
    int miscompares;

    lcd_write_sequencer dut (
        .Clock               (Clock),
        .iReset_n            (iReset_n),
        .iStart              (iStart),
        .iRS                 (iRS),
        .iData               (iData),
        .iNibbleMode         (iNibbleMode),
        .oBusy               (busy),
        .oDone               (done),
        .oLCD_Enabled        (en),
        .oLCD_RegisterSelect (rs),
        .oLCD_ReadWrite      (rw),
        .oLCD_Data           (dat)
    );

    lcd_write_sequencer #(
        .T_SETUP_CYC (1),
        .T_PW_CYC    (1),
        .T_HOLD_CYC  (1),
        .T_GAP_CYC   (1),
        .T_EXEC_CYC  (1)
    ) dut1 (
        .Clock               (Clock),
        .iReset_n            (iReset_n),
        .iStart              (iStart1),
        .iRS                 (iRS),
        .iData               (iData),
        .iNibbleMode         (iNibbleMode),
        .oBusy               (busy1),
        .oDone               (done1),
        .oLCD_Enabled        (en1),
        .oLCD_RegisterSelect (rs1),
        .oLCD_ReadWrite      (rw1),
        .oLCD_Data           (dat1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected {busy, done, E, RW} k cycles after the capture edge.
    function automatic logic [3:0] exp_ctl(int k, logic m,
                                           int s, int p, int h, int g, int e);
        int  len;
        int  k1;
        logic b, dn, ee;
        len = m ? 2 * (s + p + h) + g + e + 1 : s + p + h + e + 1;
        k1  = s + p + h + g;
        b   = (k >= 0) && (k < len);
        dn  = (k == len - 1);
        ee  = ((k >= s) && (k < s + p)) ||
              (m && (k >= k1 + s) && (k < k1 + s + p));
        return {b, dn, ee, 1'b0};
    endfunction

    // Expected {RS, data bus} while the transfer is busy.
    function automatic logic [8:0] exp_bus(int k, logic [7:0] d, logic r,
                                           logic m, int s, int p, int h,
                                           int g);
        logic [7:0] v;
        if (!m)
            v = d;
        else if (k < s + p + h + g)
            v = {d[7:4], 4'h0};
        else
            v = {d[3:0], 4'h0};
        return {r, v};
    endfunction

    task automatic chk_ctl(string tag, int k, logic [3:0] obs,
                           logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    task automatic chk_bus(string tag, int k, logic [8:0] obs,
                           logic [8:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // Caller is just after a negedge. noise: 0 quiet, 1 random inputs,
    // 2 iStart held high with random data.
    task automatic xfer(string tag, input logic [7:0] d, input logic r,
                        input logic m, input int noise);
        int len;
        len = m ? 2 * (DS + DP + DH) + DG + DE + 1 : DS + DP + DH + DE + 1;
        iData       = d;
        iRS         = r;
        iNibbleMode = m;
        iStart      = 1'b1;
        for (int k = 0; k <= len; k++) begin
            @(negedge Clock);
            chk_ctl(tag, k, {busy, done, en, rw},
                    exp_ctl(k, m, DS, DP, DH, DG, DE));
            if (k < len)
                chk_bus(tag, k, {rs, dat},
                        exp_bus(k, d, r, m, DS, DP, DH, DG));
            if (k < len) begin
                if (noise == 1) begin
                    iData       = 8'($urandom);
                    iRS         = 1'($urandom);
                    iNibbleMode = 1'($urandom);
                    iStart      = 1'($urandom);
                end else if (noise == 2) begin
                    iData       = 8'($urandom);
                    iRS         = 1'($urandom);
                    iStart      = 1'b1;
                end else begin
                    iStart = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(string tag, int n);
        iStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk_ctl(tag, i, {busy, done, en, rw}, 4'b0000);
        end
    endtask

    task automatic xfer1(string tag, input logic [7:0] d, input logic r,
                         input logic m);
        int len;
        len = m ? 2 * 3 + 1 + 1 + 1 : 3 + 1 + 1;
        iData       = d;
        iRS         = r;
        iNibbleMode = m;
        iStart1     = 1'b1;
        for (int k = 0; k <= len; k++) begin
            @(negedge Clock);
            iStart1 = 1'b0;
            chk_ctl(tag, k, {busy1, done1, en1, rw1},
                    exp_ctl(k, m, 1, 1, 1, 1, 1));
            if (k < len)
                chk_bus(tag, k, {rs1, dat1}, exp_bus(k, d, r, m, 1, 1, 1, 1));
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rr;
        logic       rm;
        vectors     = 0;
        miscompares = 0;
        iReset_n    = 1'b0;
        iStart      = 1'b0;
        iStart1     = 1'b0;
        iRS         = 1'b0;
        iData       = 8'h00;
        iNibbleMode = 1'b0;

        repeat (3) @(negedge Clock);
        chk_bus("reset_bus", 0, {rs, dat}, 9'h000);
        chk_ctl("reset_ctl", 0, {busy, done, en, rw}, 4'b0000);
        chk_ctl("reset_ctl1", 0, {busy1, done1, en1, rw1}, 4'b0000);
        iReset_n = 1'b1;
        idle("idle0", 2);

        xfer("byte_a5", 8'hA5, 1'b1, 1'b0, 0);
        idle("idle1", 3);

        xfer("nib_3c", 8'h3C, 1'b0, 1'b1, 0);
        idle("idle2", 2);

        xfer("held_5a", 8'h5A, 1'b1, 1'b0, 2);
        xfer("chain_c3", 8'hC3, 1'b0, 1'b1, 2);
        idle("idle3", 2);

        iData       = 8'h96;
        iRS         = 1'b1;
        iNibbleMode = 1'b0;
        iStart      = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        repeat (DS + 4) @(negedge Clock);
        chk_ctl("mid_pulse", DS + 4, {busy, done, en, rw}, 4'b1010);
        #2 iReset_n = 1'b0;
        #1;
        chk_ctl("async_rst", 0, {busy, done, en, rw}, 4'b0000);
        chk_bus("async_rst_bus", 0, {rs, dat}, 9'h000);
        @(negedge Clock);
        iReset_n = 1'b1;
        idle("post_rst", 2);
        xfer("after_rst_01", 8'h01, 1'b0, 1'b0, 0);
        idle("idle4", 1);

        xfer1("min_byte", 8'h7E, 1'b1, 1'b0);
        xfer1("min_nib", 8'hB4, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            rd = 8'($urandom);
            rr = 1'($urandom);
            rm = 1'($urandom);
            xfer("noise_rand", rd, rr, rm, 1);
            idle("idle_rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
